// File: rtl/kf_time_param_gen.sv
// Kalman covariance-prediction time-parameter generator.
// Computes delta_t, 0.5*dt^2, dt^3/6 and (optionally) dt^4/24 with one shared
// double-precision multiplier sequenced by an FSM; outputs update together.
// Optional feature macro: DT4_TERM_EN enables the dt^4/24 term (six multiplies);
// without it the sequence is four multiplies and dt4_24 is held at 0.

// IEEE-754 double multiplier: go/ready/finish handshake, go->finish latency 3.
// Round-to-nearest-even; subnormal inputs and results flush to signed zero.
module fp_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        ready,
   output logic        finish,
   output logic [63:0] result
);
   typedef enum logic [1:0] {M_IDLE, M_MUL, M_RND} mstate_t;

   localparam int unsigned EW = 11;
   localparam int unsigned MW = 52;

   mstate_t      mstate;
   logic         sign_r;
   logic         zero_r;
   logic         inf_r;
   logic         nan_r;
   logic [MW:0]  ma_r;
   logic [MW:0]  mb_r;
   logic [12:0]  exp_r;
   logic [105:0] prod_r;

   logic         a_zero;
   logic         b_zero;
   logic         a_spec;
   logic         b_spec;
   logic         a_nan;
   logic         b_nan;
   logic         norm;
   logic [MW-1:0] frac;
   logic         guard;
   logic         sticky;
   logic         rup;
   logic [MW:0]  frac_r;
   logic [12:0]  e_tot;
   logic [63:0]  res_c;

   // Operand classification
   always_comb begin
      a_zero = (a[62:52] == '0);
      b_zero = (b[62:52] == '0);
      a_spec = (a[62:52] == '1);
      b_spec = (b[62:52] == '1);
      a_nan  = a_spec && (a[51:0] != '0);
      b_nan  = b_spec && (b[51:0] != '0);
   end

   // Normalise, round to nearest even, and resolve special cases
   always_comb begin
      norm = prod_r[105];
      if (norm) begin
         frac   = prod_r[104:53];
         guard  = prod_r[52];
         sticky = |prod_r[51:0];
      end else begin
         frac   = prod_r[103:52];
         guard  = prod_r[51];
         sticky = |prod_r[50:0];
      end
      rup    = guard & (sticky | frac[0]);
      frac_r = {1'b0, frac} + 53'(rup);
      e_tot  = exp_r + 13'(norm) + 13'(frac_r[MW]);
      if (nan_r)
         res_c = 64'h7FF8_0000_0000_0000;
      else if (inf_r)
         res_c = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
      else if (zero_r)
         res_c = {sign_r, 63'd0};
      else if (e_tot >= 13'd3070)
         res_c = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
      else if (e_tot <= 13'd1023)
         res_c = {sign_r, 63'd0};
      else
         res_c = {sign_r, 11'(e_tot - 13'd1023), frac_r[MW-1:0]};
   end

   // Three-step sequence: latch operands, multiply mantissas, round
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstate <= M_IDLE;
         ready  <= 1'b1;
         finish <= 1'b0;
         result <= '0;
         sign_r <= 1'b0;
         zero_r <= 1'b0;
         inf_r  <= 1'b0;
         nan_r  <= 1'b0;
         ma_r   <= '0;
         mb_r   <= '0;
         exp_r  <= '0;
         prod_r <= '0;
      end else begin
         finish <= 1'b0;
         case (mstate)
            M_IDLE: begin
               if (go) begin
                  sign_r <= a[63] ^ b[63];
                  nan_r  <= a_nan | b_nan | ((a_spec | b_spec) & (a_zero | b_zero));
                  inf_r  <= a_spec | b_spec;
                  zero_r <= a_zero | b_zero;
                  ma_r   <= {~a_zero, a[51:0]};
                  mb_r   <= {~b_zero, b[51:0]};
                  exp_r  <= 13'(a[62:52]) + 13'(b[62:52]);
                  ready  <= 1'b0;
                  mstate <= M_MUL;
               end
            end
            M_MUL: begin
               prod_r <= 106'(ma_r) * 106'(mb_r);
               mstate <= M_RND;
            end
            M_RND: begin
               result <= res_c;
               finish <= 1'b1;
               ready  <= 1'b1;
               mstate <= M_IDLE;
            end
            default: mstate <= M_IDLE;
         endcase
      end
   end
endmodule

module kf_time_param_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] dt_in,
   output logic        ready,
   output logic [63:0] delta_t,
   output logic [63:0] half_dt2,
   output logic [63:0] sixth_dt3,
   output logic [63:0] dt4_24,
   output logic        valid_out
);
   localparam int unsigned DBL_WIDTH = 64;

   localparam logic [DBL_WIDTH-1:0] C_HALF  = 64'h3FE0000000000000;
   localparam logic [DBL_WIDTH-1:0] C_SIXTH = 64'h3FC5555555555555;
`ifdef DT4_TERM_EN
   localparam logic [DBL_WIDTH-1:0] C_24TH  = 64'h3FA5555555555555;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_DT2, S_HALF, S_DT3, S_SIXTH, S_DT4, S_Q24, S_DONE
   } state_t;

   state_t               state;
   logic                 issued;
   logic [DBL_WIDTH-1:0] dt_r;
   logic [DBL_WIDTH-1:0] dt2_r;
   logic [DBL_WIDTH-1:0] dt3_r;
   logic [DBL_WIDTH-1:0] h_r;
`ifdef DT4_TERM_EN
   logic [DBL_WIDTH-1:0] s_r;
   logic [DBL_WIDTH-1:0] dt4_r;
`endif

   logic                 mul_go;
   logic                 mul_busy_st;
   logic [DBL_WIDTH-1:0] mul_a;
   logic [DBL_WIDTH-1:0] mul_b;
   logic                 mul_ready;
   logic                 mul_finish;
   logic [DBL_WIDTH-1:0] mul_res;

   fp_multiplier u_mul (
      .clk    (clk),
      .rst_n  (~rst),
      .go     (mul_go),
      .a      (mul_a),
      .b      (mul_b),
      .ready  (mul_ready),
      .finish (mul_finish),
      .result (mul_res)
   );

   // Operand select per state; go fires once, on the first cycle the multiplier is ready
   always_comb begin
      mul_a       = '0;
      mul_b       = '0;
      mul_busy_st = 1'b1;
      case (state)
         S_DT2:   begin mul_a = dt_r;  mul_b = dt_r;    end
         S_HALF:  begin mul_a = dt2_r; mul_b = C_HALF;  end
         S_DT3:   begin mul_a = dt2_r; mul_b = dt_r;    end
         S_SIXTH: begin mul_a = dt3_r; mul_b = C_SIXTH; end
`ifdef DT4_TERM_EN
         S_DT4:   begin mul_a = dt2_r; mul_b = dt2_r;   end
         S_Q24:   begin mul_a = dt4_r; mul_b = C_24TH;  end
`endif
         default: mul_busy_st = 1'b0;
      endcase
      mul_go = mul_busy_st & ~issued & mul_ready;
   end

`ifndef DT4_TERM_EN
   // dt^4/24 term not built: held at zero
   assign dt4_24 = '0;
`endif

   // Sequencer: accept request, step through multiplies, publish the coefficient set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         valid_out <= 1'b0;
         issued    <= 1'b0;
         dt_r      <= '0;
         dt2_r     <= '0;
         dt3_r     <= '0;
         h_r       <= '0;
         delta_t   <= '0;
         half_dt2  <= '0;
         sixth_dt3 <= '0;
`ifdef DT4_TERM_EN
         s_r       <= '0;
         dt4_r     <= '0;
         dt4_24    <= '0;
`endif
      end else begin
         valid_out <= 1'b0;
         if (mul_go)
            issued <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dt_r   <= dt_in;
                  issued <= 1'b0;
                  ready  <= 1'b0;
                  state  <= S_DT2;
               end
            end
            S_DT2: if (mul_finish) begin
               dt2_r  <= mul_res;
               issued <= 1'b0;
               state  <= S_HALF;
            end
            S_HALF: if (mul_finish) begin
               h_r    <= mul_res;
               issued <= 1'b0;
               state  <= S_DT3;
            end
            S_DT3: if (mul_finish) begin
               dt3_r  <= mul_res;
               issued <= 1'b0;
               state  <= S_SIXTH;
            end
`ifdef DT4_TERM_EN
            S_SIXTH: if (mul_finish) begin
               s_r    <= mul_res;
               issued <= 1'b0;
               state  <= S_DT4;
            end
            S_DT4: if (mul_finish) begin
               dt4_r  <= mul_res;
               issued <= 1'b0;
               state  <= S_Q24;
            end
            S_Q24: if (mul_finish) begin
               delta_t   <= dt_r;
               half_dt2  <= h_r;
               sixth_dt3 <= s_r;
               dt4_24    <= mul_res;
               valid_out <= 1'b1;
               issued    <= 1'b0;
               state     <= S_DONE;
            end
`else
            S_SIXTH: if (mul_finish) begin
               delta_t   <= dt_r;
               half_dt2  <= h_r;
               sixth_dt3 <= mul_res;
               valid_out <= 1'b1;
               issued    <= 1'b0;
               state     <= S_DONE;
            end
`endif
            S_DONE: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kf_time_param_gen.sv
// Scoreboard bench for kf_time_param_gen: stimulus pushes expected coefficient
// sets (and the cycle valid_out must appear in); a monitor pops on valid_out.
module tb_kf_time_param_gen;
   localparam int unsigned LM = 3;
`ifdef DT4_TERM_EN
   localparam int unsigned N_OPS = 6;
`else
   localparam int unsigned N_OPS = 4;
`endif
   localparam int unsigned LAT = 1 + N_OPS * (LM + 1);

   localparam logic [63:0] D_0    = 64'h0000000000000000;
   localparam logic [63:0] D_1    = 64'h3FF0000000000000;
   localparam logic [63:0] D_2    = 64'h4000000000000000;
   localparam logic [63:0] D_M1   = 64'hBFF0000000000000;
   localparam logic [63:0] H_1    = 64'h3FE0000000000000;
   localparam logic [63:0] S_1    = 64'h3FC5555555555555;
   localparam logic [63:0] S_M1   = 64'hBFC5555555555555;
   localparam logic [63:0] H_2    = 64'h4000000000000000;
   localparam logic [63:0] S_2    = 64'h3FF5555555555555;
`ifdef DT4_TERM_EN
   localparam logic [63:0] Q_1    = 64'h3FA5555555555555;
   localparam logic [63:0] Q_2    = 64'h3FE5555555555555;
`else
   localparam logic [63:0] Q_1    = 64'h0;
   localparam logic [63:0] Q_2    = 64'h0;
`endif

   typedef struct packed {
      logic [63:0] dt;
      logic [63:0] h;
      logic [63:0] s;
      logic [63:0] q;
      logic [31:0] cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] dt_in;
   logic        ready;
   logic [63:0] delta_t;
   logic [63:0] half_dt2;
   logic [63:0] sixth_dt3;
   logic [63:0] dt4_24;
   logic        valid_out;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   kf_time_param_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dt_in     (dt_in),
      .ready     (ready),
      .delta_t   (delta_t),
      .half_dt2  (half_dt2),
      .sixth_dt3 (sixth_dt3),
      .dt4_24    (dt4_24),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every valid_out pulse must match the oldest expected set
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid: got valid_out at cycle %0d expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("delta_t",     delta_t,   mon_e.dt);
            chk("half_dt2",    half_dt2,  mon_e.h);
            chk("sixth_dt3",   sixth_dt3, mon_e.s);
            chk("dt4_24",      dt4_24,    mon_e.q);
            chk("valid_cycle", 64'(cyc),  64'(mon_e.cyc));
         end
      end
   end

   task automatic step(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200 && !ready; i++) step(1);
      chk("ready_wait", 64'(ready), 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && (sb.size() != 0 || !ready); i++) step(1);
      chk("drain_wait", 64'(sb.size()), 64'd0);
   endtask

   task automatic send(input logic [63:0] dt, input logic [63:0] h,
                       input logic [63:0] s, input logic [63:0] q);
      exp_t e;
      wait_ready();
      start = 1'b1;
      dt_in = dt;
      e.dt = dt; e.h = h; e.s = s; e.q = q; e.cyc = 32'(cyc + LAT);
      sb.push_back(e);
      step(1);
      start = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b0;
      dt_in = '0;
      step(3);
      chk("rst_delta_t",   delta_t,          64'd0);
      chk("rst_half_dt2",  half_dt2,         64'd0);
      chk("rst_sixth_dt3", sixth_dt3,        64'd0);
      chk("rst_dt4_24",    dt4_24,           64'd0);
      chk("rst_ready",     64'(ready),       64'd1);
      chk("rst_valid",     64'(valid_out),   64'd0);
      rst = 1'b0;
      step(2);

      // dt = 1.0, then check the set is held afterwards
      send(D_1, H_1, S_1, Q_1);
      wait_idle();
      step(5);
      chk("hold_half_dt2",  half_dt2,  H_1);
      chk("hold_sixth_dt3", sixth_dt3, S_1);

      // dt = 2.0
      send(D_2, H_2, S_2, Q_2);
      wait_idle();

      // dt = 0, then 2.0 with outputs holding 0 until its completion
      send(D_0, D_0, D_0, D_0);
      wait_idle();
      send(D_2, H_2, S_2, Q_2);
      step(6);
      chk("held_zero_delta_t",  delta_t,  64'd0);
      chk("held_zero_half_dt2", half_dt2, 64'd0);
      wait_idle();

      // Negative dt gives a negative dt^3/6
      send(D_M1, H_1, S_M1, Q_1);
      wait_idle();

      // start held high through the busy period and S_DONE with changing dt_in
      wait_ready();
      start = 1'b1;
      dt_in = D_1;
      e.dt = D_1; e.h = H_1; e.s = S_1; e.q = Q_1; e.cyc = 32'(cyc + LAT);
      sb.push_back(e);
      for (int i = 0; i < int'(N_OPS * (LM + 1) + 1); i++) begin
         step(1);
         dt_in = 64'h4008000000000000 + 64'(i);
      end
      step(1);
      start = 1'b0;
      wait_idle();
      step(LAT + 4);

      // Reset during S_DT3 of a dt=2.0 request discards it
      send(D_2, H_2, S_2, Q_2);
      step(9);
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      chk("midrst_delta_t",   delta_t,   64'd0);
      chk("midrst_half_dt2",  half_dt2,  64'd0);
      chk("midrst_sixth_dt3", sixth_dt3, 64'd0);
      chk("midrst_valid",     64'(valid_out), 64'd0);
      step(2);
      rst = 1'b0;
      chk("midrst_ready", 64'(ready), 64'd1);
      step(LAT + 4);

      send(D_2, H_2, S_2, Q_2);
      wait_idle();
      step(4);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
